// File: rtl/modexp_pkg.sv
// Shared definitions for the modular-exponentiation sequencer.
//   N       operand / modulus width
//   EW      width of the exponent-length field (holds 0..N)
//   IW      width of the exponent bit index (0..N-1)
//   MM_ONE  constant 1, used to leave the Montgomery domain
//   state_t sequencer states
package modexp_pkg;

  localparam int N  = 1024;
  localparam int EW = 11;
  localparam int IW = $clog2(N);

  localparam logic [N-1:0] MM_ONE = N'(1);

  // *I states issue a multiplier request; the matching *W states wait
  // for its completion pulse.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_XI   = 4'd1,
    S_XW   = 4'd2,
    S_SI   = 4'd3,
    S_SW   = 4'd4,
    S_MI   = 4'd5,
    S_MW   = 4'd6,
    S_STEP = 4'd7,
    S_OI   = 4'd8,
    S_OW   = 4'd9,
    S_FIN  = 4'd10
  } state_t;

endpackage

// File: rtl/modexp_if.sv
// Bundle between the host, the exponentiation sequencer and the Montgomery
// multiplier.
//   Host side  : start, in_x, in_e, in_elen, in_m, in_r, in_r2 -> sequencer
//                busy, done, result                          <- sequencer
//   Multiplier : mm_start, mm_a, mm_b, mm_m                  <- sequencer
//                mm_result, mm_done                          -> sequencer
// Handshake: start is a level sampled only while idle. The sequencer pulses
// mm_start for one cycle with mm_a/mm_b/mm_m already stable; they stay
// stable until the one-cycle mm_done pulse, and no new mm_start is issued
// before that pulse. done is a one-cycle pulse; result then stays valid
// until the next accepted start.
// Modports: slave = the sequencer, master = its environment.
interface modexp_if;
  import modexp_pkg::*;

  logic          start;
  logic [N-1:0]  in_x;
  logic [N-1:0]  in_e;
  logic [EW-1:0] in_elen;
  logic [N-1:0]  in_m;
  logic [N-1:0]  in_r;
  logic [N-1:0]  in_r2;
  logic          busy;
  logic          done;
  logic [N-1:0]  result;
  logic          mm_start;
  logic [N-1:0]  mm_a;
  logic [N-1:0]  mm_b;
  logic [N-1:0]  mm_m;
  logic [N-1:0]  mm_result;
  logic          mm_done;

  modport slave (
    input  start, in_x, in_e, in_elen, in_m, in_r, in_r2, mm_result, mm_done,
    output busy, done, result, mm_start, mm_a, mm_b, mm_m
  );

  modport master (
    output start, in_x, in_e, in_elen, in_m, in_r, in_r2, mm_result, mm_done,
    input  busy, done, result, mm_start, mm_a, mm_b, mm_m
  );

endinterface

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing x^e mod m through an
// external Montgomery multiplier MM(a,b) = a*b*R^-1 mod m.
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   bus        modexp_if.slave: host request/response and multiplier port
//   dbg_state  current sequencer state
module modexp_ctrl
  import modexp_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  modexp_if.slave   bus,
  output state_t    dbg_state
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_e;
  logic          r_elen_zero;
  logic [IW-1:0] r_idx;
  logic [N-1:0]  r_a;       // running accumulator, Montgomery domain
  logic [N-1:0]  r_xm;      // base in Montgomery domain
  logic [N-1:0]  r_result;
  logic [N-1:0]  r_mm_a;
  logic [N-1:0]  r_mm_b;
  logic [N-1:0]  r_mm_m;
  logic          w_ebit;
  logic          w_busy;
  logic          w_done;
  logic          w_mm_start;

  assign w_ebit = r_e[r_idx];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = (r_state != S_IDLE);
    w_done      = (r_state == S_FIN);
    w_mm_start  = (r_state == S_XI) || (r_state == S_SI) ||
                  (r_state == S_MI) || (r_state == S_OI);
    case (r_state)
      S_IDLE: if (bus.start) w_state_nxt = S_XI;
      S_XI:   w_state_nxt = S_XW;
      S_XW:   if (bus.mm_done) w_state_nxt = r_elen_zero ? S_OI : S_SI;
      S_SI:   w_state_nxt = S_SW;
      S_SW:   if (bus.mm_done) w_state_nxt = w_ebit ? S_MI : S_STEP;
      S_MI:   w_state_nxt = S_MW;
      S_MW:   if (bus.mm_done) w_state_nxt = S_STEP;
      S_STEP: w_state_nxt = (r_idx == '0) ? S_OI : S_SI;
      S_OI:   w_state_nxt = S_OW;
      S_OW:   if (bus.mm_done) w_state_nxt = S_FIN;
      S_FIN:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand registers are loaded on the transition into each *I state so
  // they are already stable in the cycle mm_start is raised.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_e         <= '0;
      r_elen_zero <= 1'b0;
      r_idx       <= '0;
      r_a         <= '0;
      r_xm        <= '0;
      r_result    <= '0;
      r_mm_a      <= '0;
      r_mm_b      <= '0;
      r_mm_m      <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_e         <= bus.in_e;
          r_elen_zero <= (bus.in_elen == '0);
          // Wraps for elen=0, but that case never enters the loop.
          r_idx       <= IW'(bus.in_elen - EW'(1));
          r_a         <= bus.in_r;
          r_mm_a      <= bus.in_x;
          r_mm_b      <= bus.in_r2;
          r_mm_m      <= bus.in_m;
        end
        S_XW: if (bus.mm_done) begin
          r_xm   <= bus.mm_result;
          r_mm_a <= r_a;
          r_mm_b <= r_elen_zero ? MM_ONE : r_a;
        end
        S_SW: if (bus.mm_done) begin
          r_a <= bus.mm_result;
          if (w_ebit) begin
            r_mm_a <= bus.mm_result;
            r_mm_b <= r_xm;
          end
        end
        S_MW: if (bus.mm_done) r_a <= bus.mm_result;
        S_STEP: begin
          r_mm_a <= r_a;
          if (r_idx == '0) begin
            r_mm_b <= MM_ONE;
          end else begin
            r_mm_b <= r_a;
            r_idx  <= r_idx - IW'(1);
          end
        end
        S_OW: if (bus.mm_done) r_result <= bus.mm_result;
        default: ;
      endcase
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.mm_start = w_mm_start;
  assign bus.result   = r_result;
  assign bus.mm_a     = r_mm_a;
  assign bus.mm_b     = r_mm_b;
  assign bus.mm_m     = r_mm_m;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_modexp_ctrl.sv
module tb_modexp_ctrl;
  import modexp_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t dbg_state;

  modexp_if bus();

  modexp_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // scoreboard
  logic [N-1:0] exp_q[$];

  // mock multiplier state
  int           lat = 5;
  logic         pending = 1'b0;
  int           cnt = 0;
  logic [N-1:0] cap_a, cap_b, cap_m;
  int           n_starts = 0;
  int           n_done = 0;
  int           last_done_cyc = -10;
  logic         spur = 1'b0;
  logic [N-1:0] rinv;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // MM(a,b) = a*b*R^-1 mod m, by plain arithmetic
  function automatic logic [N-1:0] mm_fn(input logic [N-1:0] a, b, m);
    logic [2*N-1:0] p;
    logic [2*N-1:0] mw;
    mw = {{N{1'b0}}, m};
    p  = ({{N{1'b0}}, a} % mw) * ({{N{1'b0}}, b} % mw) % mw;
    p  = (p * {{N{1'b0}}, rinv}) % mw;
    return p[N-1:0];
  endfunction

  // Reference exponentiation: repeated multiplication of small values.
  function automatic int modpow(input int x, input int e, input int elen, input int m);
    int res;
    int ev;
    ev  = e & ((1 << elen) - 1);
    res = 1 % m;
    for (int i = 0; i < ev; i++) res = (res * x) % m;
    return res;
  endfunction

  // Mock multiplier plus output compare, all sampled on the falling edge.
  always @(negedge clk) begin
    bus.mm_done = 1'b0;
    if (reset) begin
      pending = 1'b0;
    end else begin
      if (bus.mm_start) chk("no_start_while_pending", {{(N-1){1'b0}}, pending}, '0);
      if (pending) begin
        chk("mm_a_stable", bus.mm_a, cap_a);
        chk("mm_b_stable", bus.mm_b, cap_b);
        chk("mm_m_stable", bus.mm_m, cap_m);
        cnt--;
        if (cnt == 0) begin
          bus.mm_done   = 1'b1;
          bus.mm_result = mm_fn(cap_a, cap_b, cap_m);
          pending       = 1'b0;
          last_done_cyc = cyc;
        end
      end
      if (bus.mm_start) begin
        pending = 1'b1;
        cnt     = lat;
        cap_a   = bus.mm_a;
        cap_b   = bus.mm_b;
        cap_m   = bus.mm_m;
        n_starts++;
        if (spur && dbg_state == S_SI) begin
          bus.mm_done   = 1'b1;
          bus.mm_result = '1;
          spur          = 1'b0;
        end
      end
      if (bus.done) begin
        n_done++;
        chk("done_one_after_last_mm_done", N'(cyc), N'(last_done_cyc + 1));
        chk("busy_during_done", {{(N-1){1'b0}}, bus.busy}, N'(1));
        if (exp_q.size() == 0) begin
          chk("unexpected_done", N'(1), N'(0));
        end else begin
          chk("result_vs_model", bus.result, exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive_idle();
    bus.start   = 1'b0;
    bus.in_x    = N'(5);
    bus.in_e    = '1;
    bus.in_elen = EW'(1000);
    bus.in_m    = N'(77);
    bus.in_r    = N'(12);
    bus.in_r2   = N'(4);
  endtask

  task automatic launch(input int x, input int e, input int elen);
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.in_x    = N'(x);
    bus.in_e    = N'(e);
    bus.in_elen = EW'(elen);
    bus.in_m    = N'(13);
    bus.in_r    = N'(3);
    bus.in_r2   = N'(9);
    @(posedge clk); #1;
    drive_idle();   // operands must already be latched
  endtask

  task automatic run(input string name, input int x, input int e, input int elen,
                     input int l, input bit noise, input int exp_lit);
    int model;
    int ops;
    bit ok;
    model = modpow(x, e, elen, 13);
    chk({name, "_model_pin"}, N'(model), N'(exp_lit));
    exp_q.push_back(N'(model));
    ops      = 2 + elen + $countones(e & ((1 << elen) - 1));
    lat      = l;
    spur     = noise;
    n_starts = 0;
    n_done   = 0;
    launch(x, e, elen);
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (n_done != 0) begin ok = 1'b1; break; end
      if (noise && (k % 3 == 1)) begin
        bus.start = 1'b1;
        bus.in_x  = N'(3);
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    if (!ok) chk({name, "_timeout"}, N'(0), N'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({name, "_result"}, bus.result, N'(exp_lit));
    chk({name, "_done_pulses"}, N'(n_done), N'(1));
    chk({name, "_mm_ops"}, N'(n_starts), N'(ops));
    chk({name, "_busy_after"}, {{(N-1){1'b0}}, bus.busy}, '0);
    chk({name, "_queue_empty"}, N'(exp_q.size()), '0);
  endtask

  task automatic check_quiet(input string name, input bit want_zero_result);
    chk({name, "_state"}, N'(dbg_state), N'(S_IDLE));
    chk({name, "_busy"}, {{(N-1){1'b0}}, bus.busy}, '0);
    chk({name, "_done"}, {{(N-1){1'b0}}, bus.done}, '0);
    chk({name, "_mm_start"}, {{(N-1){1'b0}}, bus.mm_start}, '0);
    if (want_zero_result) chk({name, "_result"}, bus.result, '0);
  endtask

  initial begin
    int r_i;
    int ok;
    drive_idle();
    bus.mm_done   = 1'b0;
    bus.mm_result = '0;

    // R = 2^N mod 13 by repeated doubling, and its inverse mod 13
    r_i = 1;
    for (int i = 0; i < N; i++) r_i = (r_i * 2) % 13;
    chk("model_R_pin", N'(r_i), N'(3));
    chk("model_R2_pin", N'((r_i * r_i) % 13), N'(9));
    rinv = '0;
    for (int k = 1; k < 13; k++) if ((r_i * k) % 13 == 1) rinv = N'(k);
    chk("model_rinv_pin", rinv, N'(9));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset", 1'b1);
    chk("reset_mm_a", bus.mm_a, '0);
    chk("reset_mm_b", bus.mm_b, '0);
    chk("reset_mm_m", bus.mm_m, '0);
    @(posedge clk); #1;
    reset = 1'b0;

    run("e5",      7, 5,    3, 5, 1'b0, 11);
    run("e0",      7, 0,    0, 5, 1'b0, 1);
    run("e1",      7, 1,    1, 3, 1'b0, 7);
    run("e1011",   7, 11,   4, 5, 1'b0, 2);
    run("ehigh",   7, 'h1d, 3, 2, 1'b0, 11);  // bits above elen ignored
    run("noise",   7, 5,    3, 4, 1'b1, 11);
    chk("spurious_done_injected", {{(N-1){1'b0}}, spur}, '0);

    // reset in the middle of a multiply wait
    lat = 5;
    launch(7, 11, 4);
    ok = 0;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk); #1;
      if (dbg_state == S_MW) begin ok = 1; break; end
    end
    if (ok == 0) chk("reach_mw_timeout", N'(0), N'(1));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_quiet("mid_reset", 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    run("after_reset", 7, 11, 4, 5, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
